// File: rtl/rand_pool_if.sv
// Bundle of the random-pool arbiter's consumer-side signals.
// slave is the arbiter; master is the generator/consumer side that drives it.
interface rand_pool_if #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4
);
    logic [3:0]               rand_in;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         gnt;
    logic [3:0]               rand_out;
    logic                     rand_out_valid;
    logic [$clog2(DEPTH):0]   pool_count;
    logic                     tick;
    logic                     dropped;

    modport master (
        output rand_in,
        output req,
        input  gnt,
        input  rand_out,
        input  rand_out_valid,
        input  pool_count,
        input  tick,
        input  dropped
    );

    modport slave (
        input  rand_in,
        input  req,
        output gnt,
        output rand_out,
        output rand_out_valid,
        output pool_count,
        output tick,
        output dropped
    );
endinterface

// File: rtl/rand_pool_arbiter.sv
// Periodically samples and whitens a random nibble into a small pool, then
// hands pooled nibbles to requesters in round-robin order.
module rand_pool_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TICK_CYCLES = 50000000,
    parameter int DEPTH       = 4
) (
    input logic    CLK,
    input logic    reset,
    rand_pool_if.slave bus
);
    // Handshake: req is a level held by the consumer; gnt is a registered
    // one-cycle one-hot pulse with rand_out/rand_out_valid in the same cycle.
    // A req still high on the edge after its gnt competes again for a new entry.

    localparam int CW   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW   = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [CW-1:0]   tick_cnt;
    logic [3:0]      lfsr;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [PW-1:0]   rr_ptr;

    logic            tick_now;
    logic            full;
    logic            pop;
    logic            push;
    logic            found;
    logic [PW-1:0]   sel;
    logic [3:0]      sample;

    assign tick_now = (tick_cnt == CW'(TICK_CYCLES - 1));
    assign full     = (count == CNTW'(DEPTH));
    assign sample   = bus.rand_in ^ lfsr;

    // Round-robin scan starting at rr_ptr; the first asserted req wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign pop  = (count != '0) && found;
    // A pop in the same edge frees the slot the new sample needs.
    assign push = tick_now && (!full || pop);

    always_ff @(posedge CLK) begin
        if (reset) begin
            tick_cnt <= '0;
            bus.tick <= 1'b0;
        end else begin
            tick_cnt <= tick_now ? '0 : tick_cnt + CW'(1);
            bus.tick <= tick_now;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            lfsr        <= 4'b1001;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.dropped <= 1'b0;
        end else begin
            if (tick_now) begin
                lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            end
            if (push) begin
                mem[wr_ptr] <= sample;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (tick_now && full && !pop) begin
                bus.dropped <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rr_ptr             <= '0;
            bus.gnt            <= '0;
            bus.rand_out       <= '0;
            bus.rand_out_valid <= 1'b0;
        end else if (pop) begin
            bus.gnt            <= N_REQ'(1) << sel;
            bus.rand_out       <= mem[rd_ptr];
            bus.rand_out_valid <= 1'b1;
            rr_ptr             <= (int'(sel) == N_REQ - 1) ? '0 : sel + PW'(1);
        end else begin
            bus.gnt            <= '0;
            bus.rand_out       <= '0;
            bus.rand_out_valid <= 1'b0;
        end
    end

    assign bus.pool_count = count;
endmodule

// File: tb/tb_rand_pool_arbiter.sv
// Bench for rand_pool_arbiter: queue-based model checked every cycle, plus
// directed scenarios with hand-computed nibbles.
module tb_rand_pool_arbiter;
    localparam int N_REQ = 4;
    localparam int TICK  = 8;
    localparam int DEPTH = 4;

    logic CLK;
    logic reset;
    int   n_tests;
    int   n_fail;

    rand_pool_if #(.N_REQ(N_REQ), .DEPTH(DEPTH)) bus ();

    rand_pool_arbiter #(.N_REQ(N_REQ), .TICK_CYCLES(TICK), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pool is a queue, tick is "cycles since reset mod TICK".
    logic [3:0]       pool_q[$];
    logic [3:0]       m_lfsr;
    int               m_cyc;
    int               m_rr;
    logic [N_REQ-1:0] e_gnt;
    logic [3:0]       e_out;
    logic             e_valid;
    logic             e_tick;
    logic             e_drop;
    bit               model_valid;

    task automatic model_step();
        bit tick_now;
        if (reset) begin
            m_cyc = 0; m_lfsr = 4'b1001; m_rr = 0; pool_q.delete();
            e_gnt = '0; e_out = '0; e_valid = 1'b0; e_tick = 1'b0; e_drop = 1'b0;
            return;
        end
        tick_now = (m_cyc % TICK) == TICK - 1;
        m_cyc++;
        e_tick = tick_now;
        e_gnt = '0; e_out = '0; e_valid = 1'b0;
        if (pool_q.size() > 0 && bus.req != '0) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_rr + k) % N_REQ;
                if (!e_valid && bus.req[i]) begin
                    e_gnt = N_REQ'(1) << i;
                    e_out = pool_q.pop_front();
                    e_valid = 1'b1;
                    m_rr = (i + 1) % N_REQ;
                end
            end
        end
        if (tick_now) begin
            if (pool_q.size() < DEPTH) pool_q.push_back(bus.rand_in ^ m_lfsr);
            else e_drop = 1'b1;
            m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
        end
    endtask

    initial begin
        model_valid = 0;
        forever begin
            @(negedge CLK);
            if (model_valid) begin
                check("m_gnt", 32'(bus.gnt), 32'(e_gnt));
                check("m_rand_out", 32'(bus.rand_out), 32'(e_out));
                check("m_valid", 32'(bus.rand_out_valid), 32'(e_valid));
                check("m_pool_count", 32'(bus.pool_count), pool_q.size());
                check("m_tick", 32'(bus.tick), 32'(e_tick));
                check("m_dropped", 32'(bus.dropped), 32'(e_drop));
            end
            if (reset) model_valid = 1;
            if (model_valid) model_step();
        end
    end

    task automatic wait_tick(input int bound, output int cycles);
        cycles = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            cycles++;
            if (bus.tick === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL tick_timeout: got no tick, expected one within %0d cycles", bound);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        reset = 1'b1;
        bus.req = '0;
        @(posedge CLK); @(posedge CLK); #1;
        check("reset_gnt", 32'(bus.gnt), 0);
        check("reset_pool", 32'(bus.pool_count), 0);
        check("reset_dropped", 32'(bus.dropped), 0);
        reset = 1'b0;
    endtask

    task automatic fill(input int n);
        int c;
        for (int i = 0; i < n; i++) wait_tick(4 * TICK, c);
    endtask

    initial begin
        int c;
        logic [3:0] exp_q[$];
        logic [N_REQ-1:0] g;
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.req = '0;
        bus.rand_in = 4'hA;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;

        // Fill to full, then one more tick drops.
        for (int i = 0; i < 5; i++) begin
            wait_tick(4 * TICK, c);
            if (i > 0) check("tick_period", c, TICK);
            check("fill_count", 32'(bus.pool_count), (i < 4) ? i + 1 : 4);
            check("fill_dropped", 32'(bus.dropped), (i < 4) ? 0 : 1);
        end

        // Single grant of one entry.
        do_reset();
        fill(1);
        check("one_count", 32'(bus.pool_count), 1);
        @(posedge CLK); #1; bus.req = 4'b0100;
        @(posedge CLK); #1; bus.req = '0;
        check("one_gnt", 32'(bus.gnt), 32'h4);
        check("one_out", 32'(bus.rand_out), 32'h3);
        check("one_valid", 32'(bus.rand_out_valid), 1);
        check("one_count0", 32'(bus.pool_count), 0);
        @(posedge CLK); #1;
        check("one_nognt", 32'(bus.gnt), 0);

        // Full pool drained by all four requesters.
        do_reset();
        fill(4);
        @(posedge CLK); #1; bus.req = 4'b1111;
        exp_q = '{4'h3, 4'h9, 4'hC, 4'h7};
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("rr_gnt", 32'(bus.gnt), 32'(1) << i);
            check("rr_out", 32'(bus.rand_out), 32'(exp_q[i]));
        end
        @(posedge CLK); #1;
        check("rr_idle_gnt", 32'(bus.gnt), 0);
        check("rr_idle_count", 32'(bus.pool_count), 0);
        bus.req = '0;

        // Full pool; a tick lands on the same edge as a grant.
        do_reset();
        fill(4);
        repeat (7) @(posedge CLK);
        #1; bus.req = 4'b0001;
        @(posedge CLK); #1; bus.req = 4'b1111;
        check("coin_tick", 32'(bus.tick), 1);
        check("coin_gnt", 32'(bus.gnt), 1);
        check("coin_out", 32'(bus.rand_out), 32'h3);
        check("coin_count", 32'(bus.pool_count), 4);
        check("coin_dropped", 32'(bus.dropped), 0);
        exp_q = '{4'h9, 4'hC, 4'h7, 4'h0};
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("coin_drain", 32'(bus.rand_out), 32'(exp_q[i]));
        end
        bus.req = '0;

        // Two held requesters alternate as ticks refill the pool.
        do_reset();
        bus.req = 4'b1001;
        g = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            c = 0;
            while (bus.rand_out_valid !== 1'b1 && c < 4 * TICK) begin
                @(posedge CLK); #1; c++;
            end
            check("alt_gnt", 32'(bus.gnt), 32'(g));
            g = (g == 4'b0001) ? 4'b1000 : 4'b0001;
            @(posedge CLK); #1;
        end
        bus.req = '0;

        // Reset in the middle of a grant sequence.
        do_reset();
        fill(4);
        @(posedge CLK); #1; bus.req = 4'b1111;
        @(posedge CLK); @(posedge CLK); #1;
        check("mid_out", 32'(bus.rand_out), 32'h9);
        reset = 1'b1;
        @(posedge CLK); #1;
        check("mid_gnt", 32'(bus.gnt), 0);
        check("mid_valid", 32'(bus.rand_out_valid), 0);
        check("mid_count", 32'(bus.pool_count), 0);
        check("mid_dropped", 32'(bus.dropped), 0);
        reset = 1'b0;
        bus.req = '0;
        fill(1);
        @(posedge CLK); #1; bus.req = 4'b0001;
        @(posedge CLK); #1; bus.req = '0;
        check("mid_first_out", 32'(bus.rand_out), 32'h3);
        check("mid_first_gnt", 32'(bus.gnt), 1);

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
